// File: rtl/switch_debouncer.sv
// Multi-channel slide-switch debouncer: two-flop synchronizer per bit, then a
// per-channel stability counter that commits a new level after STABLE_CNT cycles.
module switch_debouncer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STABLE_CNT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             busy
);

  localparam int unsigned    CW      = $clog2(STABLE_CNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] db_next;
  logic             busy_next;

  // A channel only counts while its synchronized level disagrees with the
  // committed level; any agreement, or a commit, returns the count to zero.
  always_comb begin
    db_next   = swt_db;
    busy_next = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != swt_db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
      busy_next = busy_next | (cnt_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      swt_db <= '0;
      rise   <= '0;
      fall   <= '0;
      busy   <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= swt;
      sync2  <= sync1;
      swt_db <= db_next;
      rise   <= db_next & ~swt_db;
      fall   <= ~db_next & swt_db;
      busy   <= busy_next;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 4, number of independent switch channels.
REQ-002 Parameter STABLE_CNT, default 1000000, consecutive cycles a synchronized input must differ from its debounced value before that value flips (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 swt  input  WIDTH  raw asynchronous slide-switch levels.
REQ-006 swt_db  output  WIDTH  debounced switch levels, registered; this is the swt bus for the downstream gate logic.
REQ-007 rise  output  WIDTH  one-cycle pulse per bit when swt_db[i] goes 0->1.
REQ-008 fall  output  WIDTH  one-cycle pulse per bit when swt_db[i] goes 1->0.
REQ-009 busy  output  1  high while any channel counter is non-zero.

Function
REQ-010 Each swt[i] SHALL pass a 2-flop synchronizer (sync1, sync2) before any other use; no logic on sync1.
REQ-011 Each channel SHALL own a counter of width clog2(STABLE_CNT); channels fully independent.
REQ-012 Per edge, per channel: if sync2[i] == swt_db[i], counter clears to 0.
REQ-013 If sync2[i] != swt_db[i] and counter < STABLE_CNT-1, counter increments by 1.
REQ-014 If sync2[i] != swt_db[i] and counter == STABLE_CNT-1, swt_db[i] takes sync2[i] and counter clears on that same edge; counter never exceeds STABLE_CNT-1, never wraps.
REQ-015 Latency: raw input held stable from before edge 1 SHALL appear on swt_db at edge STABLE_CNT+2 (2 sync + STABLE_CNT qualify).
REQ-016 Any bounce (sync2 returning to swt_db for one or more cycles) SHALL clear the counter; qualification restarts from 0, no partial credit.
REQ-017 rise[i]/fall[i] SHALL be registered and assert in the same cycle swt_db[i] changes, for exactly one cycle; never both high on one bit.
REQ-018 Simultaneous qualification on several bits SHALL update all such bits and their pulses on the same edge.
REQ-019 busy SHALL be the registered OR of (counter != 0) across channels, updated with the counters.
REQ-020 swt_db SHALL change at most once per STABLE_CNT cycles per channel.

Reset
REQ-021 While rst_n is low at a clock edge: sync1, sync2, swt_db, all counters, rise, fall, busy SHALL go to 0.
REQ-022 Reset mid-qualification SHALL discard progress; swt_db returns to 0 regardless of swt.
REQ-023 After release with a switch held high, that bit SHALL re-qualify from 0 (STABLE_CNT+2 edges) and emit a rise pulse; power-up rise pulses for high switches are intended behaviour.
REQ-024 rst_n is not synchronized internally; its source is synchronous to clk.

Verification (STABLE_CNT=8, WIDTH=4)
REQ-025 Reset, swt=4'b0000 -> all outputs 0; swt=4'b0001 held, first edge after release = edge 1 -> swt_db=4'b0001 and rise=4'b0001 at edge 10, rise=0 at edge 11, busy high edges 3-9.
REQ-026 swt[1] toggles every 3 cycles for 40 cycles then settles 1 -> no change on swt_db[1], rise[1], fall[1] during toggling; swt_db[1]=1 exactly 10 edges after the final transition.
REQ-027 swt=4'b1111 -> 4'b0000 from a settled 4'b1111 -> fall=4'b1111 for one cycle, swt_db=4'b0000 on the same edge, 10 edges after the change.
REQ-028 swt[2] high for 6 cycles then low -> swt_db stays 0, counter clears, busy drops, no pulses.
REQ-029 swt=4'b1010 held, rst_n low for one edge at counter=5 -> outputs 0 that cycle; swt_db=4'b1010 with rise=4'b1010 10 edges after release.
REQ-030 swt[0] settles 5 cycles after swt[3] -> independent updates 5 edges apart, each with its own single-cycle rise.
